// File: rtl/openstrive_mem_arb_pkg.sv
// Shared types and constants for the two-port SoC SRAM arbiter.
package openstrive_mem_arb_pkg;

    localparam int unsigned DEFAULT_WORDS = 256;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BE_W          = 4;
    localparam int unsigned MEM_ADDR_W    = 22;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // Response tag captured on every grant, consumed one cycle later.
    typedef struct packed {
        logic  valid;
        port_e port;
        logic  err;
    } resp_tag_t;

endpackage

// File: rtl/openstrive_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-grant register.
module openstrive_rr_arb2
    import openstrive_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_e last;

    // Under contention the port that did not win last time is granted.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last <= PORT_D;
        end else if (gnt[0]) begin
            last <= PORT_I;
        end else if (gnt[1]) begin
            last <= PORT_D;
        end
    end

endmodule

// File: rtl/openstrive_soc_mem_arb.sv
// Arbitrates instruction and data ports onto a single 1-cycle SRAM macro.
module openstrive_soc_mem_arb
    import openstrive_mem_arb_pkg::*;
#(
    parameter int unsigned WORDS = DEFAULT_WORDS
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic        i_err,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_err,
    output logic [31:0] d_rdata,

    output logic        mem_ena,
    output logic [3:0]  mem_wen,
    output logic [21:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        sel_d;
    logic        any_gnt;
    logic        oor;
    logic [31:0] addr;
    resp_tag_t   tag;
    logic        resp_wr;
    logic        data_ok;

    // Requests are masked during reset so no grant or SRAM access escapes.
    assign req = {d_req, i_req} & {2{resetn}};

    openstrive_rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .gnt    (gnt)
    );

    assign i_gnt   = gnt[0];
    assign d_gnt   = gnt[1];
    assign sel_d   = gnt[1];
    assign any_gnt = |gnt;
    assign addr    = sel_d ? d_addr : i_addr;
    assign oor     = (addr[31:2] >= 30'(WORDS));

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    // SRAM command for the granted port; out-of-range grants skip the macro.
    always_comb begin
        mem_ena   = any_gnt & ~oor;
        mem_wen   = 4'b0000;
        mem_addr  = addr[23:2];
        mem_wdata = 32'h0;
        if (mem_ena && sel_d && d_we) begin
            mem_wen = d_be;
        end
        if (sel_d) begin
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag     <= '0;
            resp_wr <= 1'b0;
        end else begin
            tag.valid <= any_gnt;
            tag.port  <= sel_d ? PORT_D : PORT_I;
            tag.err   <= any_gnt & oor;
            resp_wr   <= any_gnt & sel_d & d_we;
        end
    end

    // Responses decode straight from the registered tag; read data only on clean reads.
    assign data_ok  = ~tag.err & ~resp_wr;
    assign i_rvalid = tag.valid && (tag.port == PORT_I);
    assign d_rvalid = tag.valid && (tag.port == PORT_D);
    assign i_err    = i_rvalid & tag.err;
    assign d_err    = d_rvalid & tag.err;
    assign i_rdata  = (i_rvalid && data_ok) ? mem_rdata : 32'h0;
    assign d_rdata  = (d_rvalid && data_ok) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_openstrive_soc_mem_arb.sv
// Directed bench for openstrive_soc_mem_arb with a behavioural 1-cycle SRAM.
module tb_openstrive_soc_mem_arb;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_ena;
    logic [3:0]  mem_wen;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    openstrive_soc_mem_arb #(.WORDS(256)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_err     (i_err),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_ena   (mem_ena),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model: byte-masked write, registered read of the old word.
    logic [31:0] mem [0:255];
    logic        unused_hi;
    assign unused_hi = ^mem_addr[21:8];

    always @(posedge clk) begin
        if (mem_ena) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wen[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the falling edge, then settle 1ns for checks.
    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [3:0] be,
                         input logic [31:0] da, input logic [31:0] dwd);
        @(negedge clk);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_be    = be;
        d_addr  = da;
        d_wdata = dwd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        resetn = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;

        // Reset state with both ports requesting
        drive(1'b1, 32'h10, 1'b1, 1'b1, 4'hF, 32'h0, 32'h1);
        chk("rst_i_gnt",    32'(i_gnt),    32'h0);
        chk("rst_d_gnt",    32'(d_gnt),    32'h0);
        chk("rst_mem_ena",  32'(mem_ena),  32'h0);
        chk("rst_mem_wen",  32'(mem_wen),  32'h0);
        chk("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("rst_errs",     32'({i_err, d_err}), 32'h0);
        chk("rst_i_rdata",  i_rdata,       32'h0);
        chk("rst_d_rdata",  d_rdata,       32'h0);
        resetn = 1'b1;

        // Preload words 0..9 through the data port
        for (int k = 0; k < 10; k++) begin
            logic [31:0] v;
            v = (k < 8) ? (32'hC0DE0000 + 32'(k)) : ((k == 8) ? 32'hA0A0A0A0 : 32'hB0B0B0B0);
            drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'(4 * k), v);
        end
        idle();

        // Fresh reset so the contention test starts from last_grant = data
        idle();
        resetn = 1'b0;
        #1;
        chk("rst2_d_rvalid", 32'(d_rvalid), 32'h0);
        #1;
        resetn = 1'b1;

        // Contention: grants alternate I,D,I,D; rvalid one cycle behind each grant
        for (int k = 0; k < 5; k++) begin
            logic both;
            both = (k < 4);
            drive(both, 32'h20, both, 1'b0, 4'hF, 32'h24, 32'hFFFFFFFF);
            if (k < 4) begin
                chk($sformatf("cont%0d_i_gnt", k), 32'(i_gnt), 32'((k % 2) == 0));
                chk($sformatf("cont%0d_d_gnt", k), 32'(d_gnt), 32'((k % 2) == 1));
                chk($sformatf("cont%0d_addr", k), 32'(mem_addr), ((k % 2) == 0) ? 32'd8 : 32'd9);
                chk($sformatf("cont%0d_wen", k), 32'(mem_wen), 32'h0);
            end
            chk($sformatf("cont%0d_i_rvalid", k), 32'(i_rvalid), 32'(k == 1 || k == 3));
            chk($sformatf("cont%0d_d_rvalid", k), 32'(d_rvalid), 32'(k == 2 || k == 4));
            chk($sformatf("cont%0d_i_rdata", k), i_rdata, (k == 1 || k == 3) ? 32'hA0A0A0A0 : 32'h0);
            chk($sformatf("cont%0d_d_rdata", k), d_rdata, (k == 2 || k == 4) ? 32'hB0B0B0B0 : 32'h0);
        end

        // Streaming: eight back-to-back data reads with no bubbles
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 32'h0, (k < 8), 1'b0, 4'h0, 32'(4 * k), 32'h0);
            chk($sformatf("strm%0d_d_gnt", k), 32'(d_gnt), 32'(k < 8));
            chk($sformatf("strm%0d_d_rvalid", k), 32'(d_rvalid), 32'(k > 0));
            if (k > 0) chk($sformatf("strm%0d_d_rdata", k), d_rdata, 32'hC0DE0000 + 32'(k - 1));
        end

        // Single instruction read of word 4
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("wr_resp_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("wr_resp_d_rdata",  d_rdata,       32'h0);
        chk("rd_i_gnt",         32'(i_gnt),    32'h1);
        chk("rd_d_gnt",         32'(d_gnt),    32'h0);
        chk("rd_mem_addr",      32'(mem_addr), 32'd4);
        chk("rd_mem_ena",       32'(mem_ena),  32'h1);
        idle();
        chk("rd_i_rvalid", 32'(i_rvalid), 32'h1);
        chk("rd_i_rdata",  i_rdata,       32'hDEADBEEF);
        chk("rd_i_err",    32'(i_err),    32'h0);

        // Byte write into word 2 then read back
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h8, 32'h11223344);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0100, 32'h8, 32'h00AB0000);
        chk("bw_mem_wen",   32'(mem_wen), 32'h4);
        chk("bw_mem_addr",  32'(mem_addr), 32'd2);
        chk("bw_mem_wdata", mem_wdata,    32'h00AB0000);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        chk("bw_rd_mem_wen", 32'(mem_wen), 32'h0);
        chk("bw_resp_rdata", d_rdata,      32'h0);
        idle();
        chk("bw_rdback", d_rdata, 32'h11AB3344);

        // Out of range: word 256 and a high-bit address; word 255 stays in range
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h400, 32'h0);
        chk("oor_d_gnt",   32'(d_gnt),   32'h1);
        chk("oor_mem_ena", 32'(mem_ena), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0100_0000, 32'h12345678);
        chk("oor_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("oor_d_err",    32'(d_err),    32'h1);
        chk("oor_d_rdata",  d_rdata,       32'h0);
        chk("oor_hi_ena",   32'(mem_ena),  32'h0);
        chk("oor_hi_wen",   32'(mem_wen),  32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h3FC, 32'h0);
        chk("edge_mem_ena", 32'(mem_ena), 32'h1);
        chk("oor_hi_err",   32'(d_err),   32'h1);
        idle();
        chk("edge_d_err", 32'(d_err), 32'h0);
        chk("edge_i_err", 32'(i_err), 32'h0);

        // Zero byte-enable write still accesses and responds, data untouched
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h24, 32'h55555555);
        chk("be0_mem_ena", 32'(mem_ena), 32'h1);
        chk("be0_mem_wen", 32'(mem_wen), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        chk("be0_resp", 32'(d_rvalid), 32'h1);
        idle();
        chk("be0_rdback", d_rdata, 32'hB0B0B0B0);

        // Reset just before the response edge drops the in-flight tag
        drive(1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("mid_i_gnt", 32'(i_gnt), 32'h1);
        #2;
        resetn = 1'b0;
        drive(1'b1, 32'h20, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        chk("mid_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("mid_i_gnt_rst", 32'(i_gnt), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_i_gnt", 32'(i_gnt), 32'h1);
        chk("post_d_gnt", 32'(d_gnt), 32'h0);
        drive(1'b1, 32'h20, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        chk("post_d_gnt2",   32'(d_gnt),    32'h1);
        chk("post_i_rvalid", 32'(i_rvalid), 32'h1);
        chk("post_i_rdata",  i_rdata,       32'hA0A0A0A0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/openstrive_soc_mem_arb.md
OPENSTRIVE_SOC_MEM_ARB -- requirements
Module: openstrive_soc_mem_arb

Interface
REQ-001 SHALL have parameter WORDS, default 256: SRAM depth in 32-bit words.
REQ-002 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1: asynchronous, active-low reset.
REQ-004 SHALL have ports i_req/i_gnt/i_rvalid/i_err  in/out/out/out  1 each: instruction-port handshake, read-only.
REQ-005 SHALL have ports i_addr  input  32 and i_rdata  output  32: instruction byte address and read data.
REQ-006 SHALL have ports d_req/d_we/d_gnt/d_rvalid/d_err  in/in/out/out/out  1 each: data-port handshake.
REQ-007 SHALL have ports d_be  input  4, d_addr  input  32, d_wdata  input  32, d_rdata  output  32: data byte enables, address, write data, read data.
REQ-008 SHALL have SRAM-side ports mem_ena  output  1, mem_wen  output  4, mem_addr  output  22, mem_wdata  output  32, mem_rdata  input  32, matching the SoC SRAM macro (1-cycle registered read).

Function
REQ-009 SHALL issue at most one SRAM access per cycle; gnt outputs SHALL be combinational and one-hot-or-zero.
REQ-010 SHALL grant the sole requester when only one port requests.
REQ-011 SHALL arbitrate round-robin when both request: grant the port not granted most recently; last_grant register updates only on a grant.
REQ-012 SHALL derive mem_addr = addr[23:2] of the granted port; addr[1:0] ignored.
REQ-013 SHALL treat addr[31:2] >= WORDS as out of range: grant, mem_ena=0, error response.
REQ-014 SHALL drive mem_ena=1 on an in-range grant; mem_wen = d_be when data port granted with d_we=1, else 4'b0000.
REQ-015 SHALL register a response tag {valid, port, err} on each grant and assert that port's rvalid exactly one cycle after gnt (latency 1), for reads and writes alike.
REQ-016 SHALL present mem_rdata on the responding port's rdata when err=0; rdata SHALL be 0 when err=1 and for writes.
REQ-017 SHALL hold err high only coincident with that port's rvalid.
REQ-018 SHALL sustain back-to-back grants: a new grant may occur in the same cycle as the previous rvalid (full throughput, 1 access/cycle).
REQ-019 SHALL drive non-granted mem outputs: mem_ena=0, mem_wen=0; mem_addr/mem_wdata don't-care.
REQ-020 SHALL ignore d_we/d_be/d_wdata for reads; d_be=0 write SHALL still access (no byte written) and respond.

Reset
REQ-021 SHALL, while resetn=0, force all gnt, rvalid, err, mem_ena, mem_wen to 0 and rdata outputs to 0.
REQ-022 SHALL reset last_grant to data port so the instruction port wins the first contended cycle.
REQ-023 SHALL discard an in-flight response tag on reset mid-operation; a write already committed to SRAM is not reverted.

Structure
REQ-024 SHALL place port-index enum (PORT_I, PORT_D), DEFAULT_WORDS and the response-tag struct in package openstrive_mem_arb_pkg.
REQ-025 SHALL isolate the two-way round-robin grant logic in one sub-module openstrive_rr_arb2 (req[1:0], last register, gnt[1:0]).
REQ-026 SHALL contain no memory array; the SRAM macro is instantiated by the SoC top.

Verification
REQ-027 Single read: i_req, i_addr=0x10 with mem word 4=0xDEADBEEF -> i_gnt same cycle, mem_addr=4, i_rvalid next cycle, i_rdata=0xDEADBEEF.
REQ-028 Contention: i_req and d_req held high 4 cycles after reset -> grants I,D,I,D; each rvalid exactly 1 cycle after its gnt.
REQ-029 Byte write: d_we=1, d_be=4'b0100, d_addr=0x8, d_wdata=0x00AB0000 on word 0x11223344 -> mem_wen=4'b0100, later read returns 0x11AB3344.
REQ-030 Out of range: WORDS=256, d_addr=0x400 -> d_gnt=1, mem_ena=0, next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-031 Reset mid-flight: assert resetn=0 the cycle after i_gnt -> no i_rvalid; after release, contended request grants I first.
REQ-032 Streaming: d_req held 8 cycles, reads of words 0..7 -> 8 consecutive d_rvalid with matching data, no bubbles.
